mlp_seq_ctrl: RTL and testbench

Sequencing controller for the 2-2-1 binary-step MLP. A single shared neuron datapath (two signed MACs, a bias add and a step) is time-multiplexed over hidden neuron 1, hidden neuron 2 and the output neuron. The block holds the nine weights and biases in a runtime-writable register bank. Inputs arrive on a valid/ready handshake and the classification result leaves on a valid/ready handshake.

---
 rtl/mlp_seq_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mlp_seq_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_seq_ctrl.sv
// Sequencing controller for a 2-2-1 binary-step MLP: one shared neuron datapath
// is time-multiplexed over hidden neuron 1, hidden neuron 2 and the output neuron.
module mlp_seq_ctrl #(
  parameter int unsigned DW = 10,
  parameter int unsigned AW = 22,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] x1,
  input  logic [DW-1:0] x2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          y,
  input  logic          cfg_we,
  input  logic [3:0]    cfg_addr,
  input  logic [DW-1:0] cfg_data,
  output logic          cfg_err,
  output logic          busy,
  output logic [CW-1:0] inf_count
);

  localparam int unsigned NREG = 9;
  localparam int unsigned PW   = 2 * DW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_H1,
    S_H2,
    S_OUT,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic signed [DW-1:0]  r_bank [NREG];
  logic signed [DW-1:0]  r_x1;
  logic signed [DW-1:0]  r_x2;
  logic                  r_h1;
  logic                  r_h2;
  logic                  r_y;
  logic                  r_out_valid;
  logic                  r_cfg_err;
  logic                  r_in_ready;
  logic                  r_busy;
  logic [CW-1:0]         r_inf_count;

  logic                  w_accept;
  logic                  w_cfg_ok;
  logic signed [DW-1:0]  w_wa;
  logic signed [DW-1:0]  w_wb;
  logic signed [DW-1:0]  w_bias;
  logic signed [DW-1:0]  w_opa;
  logic signed [DW-1:0]  w_opb;
  logic signed [PW-1:0]  w_pa;
  logic signed [PW-1:0]  w_pb;
  logic signed [AW-1:0]  w_acc;
  logic                  w_step;

  function automatic logic signed [DW-1:0] bank_default(input int unsigned idx);
    logic signed [DW-1:0] v;
    case (idx)
      0:       v = DW'(2);
      1:       v = DW'(-1);
      2:       v = DW'(-3);
      3:       v = DW'(-1);
      4:       v = DW'(2);
      5:       v = DW'(1);
      6:       v = DW'(-2);
      7:       v = DW'(3);
      default: v = DW'(0);
    endcase
    return v;
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_cfg_ok = (r_state == S_IDLE) && (cfg_addr < 4'd9);
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = S_H1;
        end
      end
      S_H1:    w_next = S_H2;
      S_H2:    w_next = S_OUT;
      S_OUT:   w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand/weight select for the shared neuron
  always_comb begin
    w_opa  = r_x1;
    w_opb  = r_x2;
    w_wa   = r_bank[0];
    w_wb   = r_bank[1];
    w_bias = r_bank[2];
    case (r_state)
      S_H2: begin
        w_wa   = r_bank[3];
        w_wb   = r_bank[4];
        w_bias = r_bank[5];
      end
      S_OUT: begin
        w_opa  = {{(DW-1){1'b0}}, r_h1};
        w_opb  = {{(DW-1){1'b0}}, r_h2};
        w_wa   = r_bank[6];
        w_wb   = r_bank[7];
        w_bias = r_bank[8];
      end
      default: begin
        w_opa = r_x1;
      end
    endcase
  end

  // Two signed MACs plus bias; AW is wide enough that the sum cannot overflow
  assign w_pa   = PW'(w_wa) * PW'(w_opa);
  assign w_pb   = PW'(w_wb) * PW'(w_opb);
  assign w_acc  = AW'(w_pa) + AW'(w_pb) + AW'(w_bias);
  assign w_step = ~w_acc[AW-1];

  // Datapath, weight bank and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_bank[i] <= bank_default(i);
      end
      r_x1        <= '0;
      r_x2        <= '0;
      r_h1        <= 1'b0;
      r_h2        <= 1'b0;
      r_y         <= 1'b0;
      r_out_valid <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_inf_count <= '0;
    end else begin
      r_cfg_err  <= cfg_we && !w_cfg_ok;
      r_in_ready <= (w_next == S_IDLE);
      r_busy     <= (w_next != S_IDLE);
      if (cfg_we && w_cfg_ok) begin
        r_bank[cfg_addr] <= cfg_data;
      end
      if (w_accept) begin
        r_x1 <= x1;
        r_x2 <= x2;
      end
      case (r_state)
        S_H1: r_h1 <= w_step;
        S_H2: r_h2 <= w_step;
        S_OUT: begin
          r_y         <= w_step;
          r_out_valid <= 1'b1;
          r_inf_count <= r_inf_count + CW'(1);
        end
        S_DONE: if (out_ready) r_out_valid <= 1'b0;
        default: r_h1 <= r_h1;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign cfg_err   = r_cfg_err;
  assign busy      = r_busy;
  assign inf_count = r_inf_count;

endmodule

// File: tb/tb_mlp_seq_ctrl.sv
// Scoreboard bench for mlp_seq_ctrl: the driver pushes expected results from an
// arithmetic reference model, an independent monitor pops them at each output handshake.
module tb_mlp_seq_ctrl;

  localparam int unsigned DW = 10;
  localparam int unsigned AW = 22;
  localparam int unsigned CW = 8;

  typedef struct {
    bit     y;
    longint acc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] x1;
  logic [DW-1:0] x2;
  logic          out_valid;
  logic          out_ready;
  logic          y;
  logic          cfg_we;
  logic [3:0]    cfg_addr;
  logic [DW-1:0] cfg_data;
  logic          cfg_err;
  logic          busy;
  logic [CW-1:0] inf_count;

  exp_t   q[$];
  int     bank_m[9];
  int     n_vec = 0;
  int     n_err = 0;
  int     cyc = 0;
  int     m_count = 0;
  bit     exp_err = 0;
  bit     hs_pending = 0;
  bit     prev_ov = 0;
  bit     prev_y = 0;

  mlp_seq_ctrl #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .busy(busy), .inf_count(inf_count)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reset_bank_m();
    bank_m = '{2, -1, -3, -1, 2, 1, -2, 3, 0};
  endtask

  function automatic bit neuron(longint wa, longint a, longint wb, longint b, longint c);
    return (wa * a + wb * b + c) >= 0;
  endfunction

  function automatic bit model(logic [DW-1:0] a, logic [DW-1:0] b);
    longint sa;
    longint sb;
    bit h1;
    bit h2;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h1 = neuron(bank_m[0], sa, bank_m[1], sb, bank_m[2]);
    h2 = neuron(bank_m[3], sa, bank_m[4], sb, bank_m[5]);
    return neuron(bank_m[6], longint'(h1), bank_m[7], longint'(h2), bank_m[8]);
  endfunction

  // One clock of stimulus; the block is idle exactly when nothing is outstanding
  task automatic do_cycle(input bit iv, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input bit we, input logic [3:0] ad, input logic [DW-1:0] d);
    bit   idle;
    bit   e;
    exp_t t;
    in_valid = iv;
    x1       = a;
    x2       = b;
    cfg_we   = we;
    cfg_addr = ad;
    cfg_data = d;
    @(negedge clk);
    idle = (q.size() == 0);
    e    = 1'b0;
    if (we) begin
      if (idle && ad < 4'd9) bank_m[ad] = int'($signed(d));
      else e = 1'b1;
    end
    if (iv && idle) begin
      t.y   = model(a, b);
      t.acc = longint'(cyc + 1);
      q.push_back(t);
    end
    @(posedge clk);
    #1;
    exp_err = e;
  endtask

  task automatic idle_cycle();
    do_cycle(1'b0, '0, '0, 1'b0, 4'd0, '0);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      idle_cycle();
      n++;
    end
    if (n >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
    end
    idle_cycle();
  endtask

  // Monitor: samples 3 time units after each rising edge
  initial begin
    exp_t t;
    forever begin
      @(posedge clk);
      #3;
      if (rst) begin
        prev_ov    = 1'b0;
        hs_pending = 1'b0;
      end else begin
        if (hs_pending) begin
          t = q.pop_front();
          hs_pending = 1'b0;
        end
        chk("in_ready", longint'(in_ready), longint'(q.size() == 0));
        chk("busy", longint'(busy), longint'(q.size() != 0));
        chk("cfg_err", longint'(cfg_err), longint'(exp_err));
        if (out_valid) begin
          if (q.size() == 0) begin
            chk("out_valid", longint'(out_valid), 0);
          end else begin
            if (!prev_ov) chk("latency", longint'(cyc) - q[0].acc, 3);
            else chk("y_hold", longint'(y), longint'(prev_y));
            if (out_ready) begin
              chk("y", longint'(y), longint'(q[0].y));
              m_count = (m_count + 1) % 256;
              chk("inf_count", longint'(inf_count), longint'(m_count));
              hs_pending = 1'b1;
            end
          end
        end
        prev_ov = out_valid;
        prev_y  = y;
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    x1        = '0;
    x2        = '0;
    out_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    reset_bank_m();
    #12;
    chk("rst_y", longint'(y), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_inf_count", longint'(inf_count), 0);
    chk("rst_cfg_err", longint'(cfg_err), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_busy", longint'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Default weights, then both output polarities
    do_cycle(1'b1, 10'd3, 10'd2, 1'b0, 4'd0, '0);
    drain();
    do_cycle(1'b1, 10'd5, 10'd0, 1'b0, 4'd0, '0);
    drain();
    do_cycle(1'b1, 10'd0, 10'd0, 1'b0, 4'd0, '0);
    drain();

    // Backpressure: result held while in_valid is presented and ignored
    out_ready = 1'b0;
    do_cycle(1'b1, 10'd3, 10'd2, 1'b0, 4'd0, '0);
    for (int i = 0; i < 9; i++) do_cycle(1'b1, DW'($urandom), DW'($urandom), 1'b0, 4'd0, '0);
    out_ready = 1'b1;
    drain();

    // Config writes: plain, same edge as accept, bad address, while busy
    do_cycle(1'b0, '0, '0, 1'b1, 4'd8, 10'h3FC);
    do_cycle(1'b1, 10'd3, 10'd2, 1'b0, 4'd0, '0);
    drain();
    do_cycle(1'b1, 10'd3, 10'd2, 1'b1, 4'd8, 10'd5);
    drain();
    do_cycle(1'b0, '0, '0, 1'b1, 4'd8, 10'h3FC);
    do_cycle(1'b0, '0, '0, 1'b1, 4'd9, 10'd7);
    do_cycle(1'b0, '0, '0, 1'b1, 4'd15, 10'd7);
    do_cycle(1'b1, 10'd3, 10'd2, 1'b0, 4'd0, '0);
    idle_cycle();
    do_cycle(1'b0, '0, '0, 1'b1, 4'd8, 10'd100);
    drain();

    // Extreme weights and features
    do_cycle(1'b0, '0, '0, 1'b1, 4'd0, 10'h1FF);
    do_cycle(1'b0, '0, '0, 1'b1, 4'd1, 10'h1FF);
    do_cycle(1'b0, '0, '0, 1'b1, 4'd2, 10'h1FF);
    do_cycle(1'b1, 10'h200, 10'h200, 1'b0, 4'd0, '0);
    drain();
    do_cycle(1'b1, 10'd3, 10'd2, 1'b0, 4'd0, '0);
    drain();

    // Asynchronous reset in the middle of H2
    do_cycle(1'b1, 10'd3, 10'd2, 1'b0, 4'd0, '0);
    idle_cycle();
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_y", longint'(y), 0);
    chk("midrst_inf_count", longint'(inf_count), 0);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_in_ready", longint'(in_ready), 1);
    q.delete();
    m_count = 0;
    exp_err = 1'b0;
    reset_bank_m();
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_cycle(1'b1, 10'd3, 10'd2, 1'b0, 4'd0, '0);
    drain();

    // Randomized traffic long enough to wrap inf_count
    for (int i = 0; i < 2600; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      do_cycle(($urandom_range(0, 3) != 0), DW'($urandom), DW'($urandom),
               ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 10)), DW'($urandom));
    end
    out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
